deserialize8x4: RTL
===================

DESERIALIZE8X4 -- requirements
Module: Deserialize8x4

Interface
REQ-001 The block SHALL have no parameters; lane count 8 and lane width 4 are fixed.
REQ-002 CLK  input  1  Sole clock; all state changes on its rising edge.
REQ-003 RESET  input  1  Reset; synchronous, active-high.
REQ-004 I  input  4  Serial input word.
REQ-005 I_valid  input  1  Upstream asserts when I holds a word.
REQ-006 I_ready  output  1  Block can accept I this cycle.
REQ-007 O0..O7  output  4 each  Parallel lane outputs; O0 holds the first word of a group, O7 the eighth.
REQ-008 O_valid  output  1  Group of 8 lanes is complete and held stable.
REQ-009 O_ready  input  1  Downstream (e.g. the 8-input, 4-bit AND-reduction bank) accepts the group.
REQ-010 Cnt  output  3  Number of words accepted into the current partial group.

Function
REQ-011 The block SHALL implement two states: FILL and HOLD.
REQ-012 Input transfer SHALL occur on any cycle with I_valid=1 and I_ready=1.
REQ-013 Output transfer SHALL occur on any cycle with O_valid=1 and O_ready=1.
REQ-014 In FILL, I_ready SHALL be 1 and O_valid SHALL be 0.
REQ-015 In FILL, each input transfer SHALL write I into lane O[Cnt] and increment Cnt.
REQ-016 The input transfer at Cnt=7 SHALL write O7, wrap Cnt to 0 and enter HOLD.
REQ-017 O_valid SHALL rise on the cycle after the eighth input transfer (latency 1 cycle from final word to valid).
REQ-018 In HOLD, O_valid SHALL be 1.
REQ-019 In HOLD, O0..O7 SHALL remain unchanged until an output transfer occurs.
REQ-020 In HOLD, I_ready SHALL equal O_ready (combinational), so a full group never overwrites undelivered data.
REQ-021 In HOLD with O_ready=0, the block SHALL keep HOLD and ignore I_valid.
REQ-022 In HOLD with O_ready=1 and I_valid=0, the block SHALL enter FILL with Cnt=0.
REQ-023 In HOLD with O_ready=1 and I_valid=1 (simultaneous drain and accept), the block SHALL write I into O0, set Cnt=1 and enter FILL, with no bubble.
REQ-024 Sustained throughput SHALL be one word per cycle, i.e. one group per 8 cycles when O_ready is held 1.
REQ-025 Lanes not yet rewritten in a new group SHALL retain their previous-group values; they are don't-care while O_valid=0.
REQ-026 I_valid=0 cycles in FILL SHALL stall Cnt and leave all lanes unchanged.
REQ-027 O_valid SHALL depend only on state (registered), not on any input.

Reset
REQ-028 On a CLK edge with RESET=1, the block SHALL enter FILL with Cnt=0, O0..O7=0 and O_valid=0.
REQ-029 RESET SHALL take priority over any simultaneous input or output transfer.
REQ-030 RESET asserted during a partial group or in HOLD SHALL discard that group.
REQ-031 I_ready SHALL be 1 from the first cycle after reset.
REQ-032 I_ready SHALL be held 1 while RESET is high, but transfers in those cycles SHALL have no effect.

Verification
REQ-033 Basic fill: after reset, feed I=0x1..0x8 with I_valid=1 continuously and O_ready=0 -> O_valid=1 on cycle 9, O0..O7=1..8, I_ready=0, Cnt=0.
REQ-034 Back-to-back: hold O_ready=1, stream 16 words 0x0..0xF -> two output transfers, 8 cycles apart; first group O0..O7=0..7, second group 8..F; I_ready never drops.
REQ-035 Backpressure: complete a group of 0xA words, hold O_ready=0 for 5 cycles while I_valid=1 with I=0x3 -> lanes stay 0xA and Cnt stays 0; on release, the 0x3 on that cycle lands in O0 and Cnt=1.
REQ-036 Input gaps: insert I_valid=0 after words 2 and 5 -> Cnt holds across the gaps; O_valid asserts exactly one cycle after the 8th accepted word.
REQ-037 Reset mid-group: accept 5 words, then pulse RESET for one cycle while I_valid=1 -> Cnt=0, lanes 0, O_valid=0; the next 8 words form a clean group.
REQ-038 Reset in HOLD with O_ready=1: the group is not delivered; O_valid=0 on the next cycle.

Source files
------------

// File: rtl/deserialize8x4.sv
// Deserializer collecting eight 4-bit words into a parallel group of eight lanes.
// A group is collected in FILL, then held for downstream in HOLD. The word
// offered in the cycle that drains a group is accepted into lane 0, so
// sustained throughput is one word per cycle.
//
// Ports:
//   CLK      in   1  clock, rising edge
//   RESET    in   1  synchronous, active-high reset
//   I        in   4  serial input word
//   I_valid  in   1  upstream word present
//   I_ready  out  1  block accepts I this cycle (equals O_ready while holding)
//   O0..O7   out  4  parallel lanes; O0 is the first word of a group
//   O_valid  out  1  complete group held stable
//   O_ready  in   1  downstream accepts the group
//   Cnt      out  3  words accepted into the current partial group
module deserialize8x4 (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] I,
  input  logic       I_valid,
  output logic       I_ready,
  output logic [3:0] O0,
  output logic [3:0] O1,
  output logic [3:0] O2,
  output logic [3:0] O3,
  output logic [3:0] O4,
  output logic [3:0] O5,
  output logic [3:0] O6,
  output logic [3:0] O7,
  output logic       O_valid,
  input  logic       O_ready,
  output logic [2:0] Cnt
);

  localparam int unsigned LANES   = 8;
  localparam int unsigned LANE_W  = 4;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [LANE_W-1:0]   lane_q [LANES];
  logic                wr_en;
  logic [CNT_W-1:0]    wr_idx;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the eighth accepted word closes the group; a drain reopens FILL
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (I_valid && (cnt_q == CNT_W'(LANES - 1))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (O_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output and lane-write decode
  always_comb begin
    I_ready = 1'b1;
    O_valid = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        I_ready = 1'b1;
        wr_en   = I_valid;
        wr_idx  = cnt_q;
        if (I_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // Accepting only when the held group drains keeps it from being overwritten
        I_ready = O_ready;
        O_valid = 1'b1;
        wr_en   = O_ready && I_valid;
        wr_idx  = '0;
        if (O_ready) begin
          cnt_d = I_valid ? CNT_W'(1) : CNT_W'(0);
        end
      end
      default: begin
        I_ready = 1'b1;
      end
    endcase
    // Ready stays high through reset; the reset branch below discards any write
    if (RESET) begin
      I_ready = 1'b1;
    end
  end

  // Lane storage and word counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) begin
        lane_q[wr_idx] <= I;
      end
    end
  end

  assign O0  = lane_q[0];
  assign O1  = lane_q[1];
  assign O2  = lane_q[2];
  assign O3  = lane_q[3];
  assign O4  = lane_q[4];
  assign O5  = lane_q[5];
  assign O6  = lane_q[6];
  assign O7  = lane_q[7];
  assign Cnt = cnt_q;

endmodule
